// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter for the 4-core MESI system: round-robin processor tenures
// with nested snoop grants, forced revoke after MAX_HOLD cycles, and turnaround gaps.
module com_bus_arbiter #(
    parameter int N_PROC   = 8,
    parameter int N_SNOOP  = 4,
    parameter int MAX_HOLD = 64,
    parameter int TURN_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PROC-1:0]         Com_Bus_Req_proc,
    output logic [N_PROC-1:0]         Com_Bus_Gnt_proc,
    input  logic [N_SNOOP-1:0]        Com_Bus_Req_snoop,
    output logic [N_SNOOP-1:0]        Com_Bus_Gnt_snoop,
    output logic [$clog2(N_PROC)-1:0] Bus_owner,
    output logic                      Bus_busy,
    output logic                      Bus_timeout
);

    localparam int PW = $clog2(N_PROC);
    localparam int SW = $clog2(N_SNOOP);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PROC, SNOOP_ONLY, TURN} state_t;

    state_t        state;
    logic [PW-1:0] proc_ptr;
    logic [SW-1:0] snoop_ptr;
    logic [SW-1:0] snoop_idx;
    logic [7:0]    hold_cnt;
    logic [1:0]    turn_cnt;
    logic          turn_pending;

    logic [PW-1:0] proc_pick;
    logic [PW-1:0] proc_next;
    logic [SW-1:0] snoop_pick;
    logic [SW-1:0] snoop_next;
    logic          proc_rel;
    logic          proc_tmo;
    logic          proc_end;
    logic          snoop_active;
    logic          snoop_rel;

    function automatic logic [PW-1:0] pick_proc(input logic [N_PROC-1:0] req,
                                                input logic [PW-1:0] ptr);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_PROC; i++) begin
            idx = PW'((int'(ptr) + i) % N_PROC);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [SW-1:0] pick_snoop(input logic [N_SNOOP-1:0] req,
                                                 input logic [SW-1:0] ptr);
        logic [SW-1:0] sel;
        logic [SW-1:0] idx;
        logic          found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_SNOOP; i++) begin
            idx = SW'((int'(ptr) + i) % N_SNOOP);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign proc_pick    = pick_proc(Com_Bus_Req_proc, proc_ptr);
    assign snoop_pick   = pick_snoop(Com_Bus_Req_snoop, snoop_ptr);
    assign proc_next    = PW'((int'(Bus_owner) + 1) % N_PROC);
    assign snoop_next   = SW'((int'(snoop_idx) + 1) % N_SNOOP);
    assign proc_rel     = !Com_Bus_Req_proc[Bus_owner];
    assign proc_tmo     = !proc_rel && (hold_cnt == HOLD_LAST);
    assign proc_end     = proc_rel || proc_tmo;
    assign snoop_active = |Com_Bus_Gnt_snoop;
    assign snoop_rel    = snoop_active && !Com_Bus_Req_snoop[snoop_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Bus_owner         <= '0;
            Bus_busy          <= 1'b0;
            Bus_timeout       <= 1'b0;
            proc_ptr          <= '0;
            snoop_ptr         <= '0;
            snoop_idx         <= '0;
            hold_cnt          <= '0;
            turn_cnt          <= '0;
            turn_pending      <= 1'b0;
        end else begin
            Bus_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // Snoop traffic wins an idle bus so flushes never wait behind a tenure
                    if (|Com_Bus_Req_snoop) begin
                        snoop_idx         <= snoop_pick;
                        Com_Bus_Gnt_snoop <= N_SNOOP'(1) << snoop_pick;
                        turn_pending      <= 1'b0;
                        state             <= SNOOP_ONLY;
                    end else if (|Com_Bus_Req_proc) begin
                        Bus_owner        <= proc_pick;
                        Com_Bus_Gnt_proc <= N_PROC'(1) << proc_pick;
                        Bus_busy         <= 1'b1;
                        hold_cnt         <= '0;
                        state            <= PROC;
                    end
                end
                PROC: begin
                    if (snoop_rel) begin
                        Com_Bus_Gnt_snoop <= '0;
                        snoop_ptr         <= snoop_next;
                    end else if (!snoop_active && !proc_end && |Com_Bus_Req_snoop) begin
                        snoop_idx         <= snoop_pick;
                        Com_Bus_Gnt_snoop <= N_SNOOP'(1) << snoop_pick;
                    end
                    if (proc_end) begin
                        Com_Bus_Gnt_proc <= '0;
                        Bus_busy         <= 1'b0;
                        Bus_timeout      <= proc_tmo;
                        proc_ptr         <= proc_next;
                        hold_cnt         <= '0;
                        turn_cnt         <= '0;
                        // A snoop still in flight finishes first; the turnaround follows it
                        if (snoop_active && !snoop_rel) begin
                            turn_pending <= 1'b1;
                            state        <= SNOOP_ONLY;
                        end else begin
                            state <= (TURN_CYC > 0) ? TURN : IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                SNOOP_ONLY: begin
                    if (snoop_rel) begin
                        Com_Bus_Gnt_snoop <= '0;
                        snoop_ptr         <= snoop_next;
                        turn_cnt          <= '0;
                        turn_pending      <= 1'b0;
                        state             <= (turn_pending && TURN_CYC > 0) ? TURN : IDLE;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
